// File: rtl/fetch_prefetch_stage.sv
// Instruction-fetch front end: owns the fetch PC, runs the req/ack handshake with
// instruction memory and buffers up to two {pc, ir} pairs for decode.
module fetch_prefetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        stall,
    output logic        valid,
    output logic [15:0] ir,
    output logic [15:0] currpc
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DRAIN
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] fpc_q, fpc_d;
    logic [15:0] drain_addr_q, drain_addr_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] buf_q [2];
    logic [31:0] buf_d [2];
    logic        pop, push, room;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            fpc_q        <= RESET_PC;
            drain_addr_q <= RESET_PC;
            count_q      <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            fpc_q        <= fpc_d;
            drain_addr_q <= drain_addr_d;
            count_q      <= count_d;
            for (int unsigned i = 0; i < 2; i++) begin
                buf_q[i] <= buf_d[i];
            end
        end
    end

    always_comb begin
        pop  = (count_q != 2'd0) && !stall && !redirect;
        push = (state_q == REQ) && imem_ack && !redirect;

        // Pop shifts the head out first, so a same-edge push lands behind the survivor.
        buf_d[0] = buf_q[0];
        buf_d[1] = buf_q[1];
        count_d  = count_q;
        if (pop) begin
            buf_d[0] = buf_q[1];
            count_d  = count_q - 2'd1;
        end
        if (push) begin
            buf_d[count_d[0]] = {fpc_q, imem_rdata};
            count_d           = count_d + 2'd1;
        end
        if (redirect) begin
            count_d = '0;
        end

        if (redirect) begin
            fpc_d = redirect_pc;
        end else if (push) begin
            fpc_d = fpc_q + 16'd2;
        end else begin
            fpc_d = fpc_q;
        end

        drain_addr_d = (state_q == DRAIN) ? drain_addr_q : fpc_q;
        room         = (count_d <= 2'd1);

        state_d = state_q;
        if (redirect) begin
            state_d = ((state_q != IDLE) && !imem_ack) ? DRAIN : REQ;
        end else begin
            unique case (state_q)
                IDLE:    if (room) state_d = REQ;
                REQ:     if (imem_ack) state_d = room ? REQ : IDLE;
                DRAIN:   if (imem_ack) state_d = REQ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        imem_req  = (state_q != IDLE);
        imem_addr = (state_q == DRAIN) ? drain_addr_q : fpc_q;
        valid     = (count_q != 2'd0);
        ir        = valid ? buf_q[0][15:0]  : '0;
        currpc    = valid ? buf_q[0][31:16] : '0;
    end

endmodule

// File: tb/tb_fetch_prefetch_stage.sv
// Randomized bench for fetch_prefetch_stage against a queue-based reference model,
// plus a reset-PC wrap check on a second instance.
module tb_fetch_prefetch_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, imem_req, imem_ack, redirect, stall, valid;
    logic [15:0] imem_addr, imem_rdata, redirect_pc, ir, currpc;

    logic        rst_w, imem_req_w, imem_ack_w, redirect_w, stall_w, valid_w;
    logic [15:0] imem_addr_w, imem_rdata_w, redirect_pc_w, ir_w, currpc_w;

    fetch_prefetch_stage dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect(redirect),
        .redirect_pc(redirect_pc), .stall(stall), .valid(valid), .ir(ir), .currpc(currpc)
    );

    fetch_prefetch_stage #(.RESET_PC(16'hFFFE)) dut_w (
        .clk(clk), .rst(rst_w), .imem_req(imem_req_w), .imem_addr(imem_addr_w),
        .imem_ack(imem_ack_w), .imem_rdata(imem_rdata_w), .redirect(redirect_w),
        .redirect_pc(redirect_pc_w), .stall(stall_w), .valid(valid_w), .ir(ir_w),
        .currpc(currpc_w)
    );

    assign imem_rdata_w = imem_addr_w + 16'hA000;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a queue of {pc, ir}, a fetch PC and the outstanding request.
    logic [31:0] mq [$];
    logic [15:0] m_fpc, m_raddr;
    bit          m_out, m_disc;
    int unsigned wait_left;
    int unsigned phase;

    function automatic int unsigned new_wait();
        return (phase == 0) ? 0 : $urandom_range(0, 3);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_fpc   = 16'h0000;
        m_raddr = 16'h0000;
        m_out   = 0;
        m_disc  = 0;
    endtask

    task automatic model_edge(input bit redir, input logic [15:0] rpc, input bit stl,
                              input bit ack, input logic [15:0] rd);
        if (redir) begin
            mq.delete();
            if (m_out && !ack) begin
                if (!m_disc) m_raddr = m_fpc;
                m_disc = 1;
            end else begin
                m_out  = 1;
                m_disc = 0;
            end
            m_fpc = rpc;
        end else begin
            if (mq.size() != 0 && !stl) void'(mq.pop_front());
            if (m_out && ack) begin
                if (m_disc) begin
                    m_disc = 0;
                end else begin
                    mq.push_back({m_fpc, rd});
                    m_fpc = m_fpc + 16'd2;
                    m_out = (mq.size() <= 1);
                end
            end else if (!m_out) begin
                m_out = (mq.size() <= 1);
            end
        end
    endtask

    task automatic compare_all();
        logic [31:0] head;
        check("req", 16'(imem_req), 16'(m_out));
        check("valid", 16'(valid), 16'(mq.size() != 0));
        head = (mq.size() != 0) ? mq[0] : 32'h0;
        check("ir", ir, head[15:0]);
        check("currpc", currpc, head[31:16]);
        if (m_out) check("addr", imem_addr, m_disc ? m_raddr : m_fpc);
    endtask

    task automatic do_reset();
        #2;
        rst      = 1'b1;
        imem_ack = 1'b1;
        #1;
        check("rst_req", 16'(imem_req), 16'h0000);
        check("rst_valid", 16'(valid), 16'h0000);
        check("rst_ir", ir, 16'h0000);
        check("rst_currpc", currpc, 16'h0000);
        check("rst_addr", imem_addr, 16'h0000);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        compare_all();
        rst       = 1'b0;
        imem_ack  = 1'b0;
        redirect  = 1'b0;
        wait_left = new_wait();
    endtask

    initial begin
        logic [15:0] e;
        bit          ack_v;
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; redirect = 1'b0;
        redirect_pc = '0; stall = 1'b0;
        rst_w = 1'b1; imem_ack_w = 1'b1; redirect_w = 1'b0; redirect_pc_w = '0; stall_w = 1'b0;
        phase = 0;
        model_reset();
        wait_left = 0;

        repeat (2) @(negedge clk);
        compare_all();
        check("reset_addr", imem_addr, 16'h0000);
        rst = 1'b0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            phase = (cyc / 200) % 3;
            case (phase)
                0:       stall = 1'b0;
                1:       stall = ($urandom_range(0, 9) < 3);
                default: stall = ($urandom_range(0, 9) < 8);
            endcase
            redirect = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 2))
                0:       redirect_pc = 16'h0100;
                1:       redirect_pc = 16'hFFFC;
                default: redirect_pc = 16'($urandom) & 16'hFFFE;
            endcase
            ack_v      = m_out && (wait_left == 0);
            imem_ack   = ack_v;
            imem_rdata = 16'($urandom);
            @(posedge clk);
            if (ack_v) wait_left = new_wait();
            else if (m_out && wait_left > 0) wait_left--;
            model_edge(redirect, redirect_pc, stall, ack_v, imem_rdata);
            @(negedge clk);
            compare_all();
            if ($urandom_range(0, 249) == 0) do_reset();
        end

        // Reset PC at the top of the address space: fetch wraps to 0.
        rst_w = 1'b0;
        @(negedge clk);
        check("w_req", 16'(imem_req_w), 16'h0001);
        check("w_valid0", 16'(valid_w), 16'h0000);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            e = 16'hFFFE + 16'(2 * k);
            check("w_valid", 16'(valid_w), 16'h0001);
            check("w_currpc", currpc_w, e);
            check("w_ir", ir_w, e + 16'hA000);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
